// File: rtl/sd_dat_rx_ctrl.sv
// sd_dat_rx_ctrl: receive sequencer for the 4-bit SD DAT bus.
// Gates the deserializer per block, pushes words, checks lane CRC16 and end bit.
module sd_dat_rx_ctrl #(
   parameter int BLOCK_WORDS = 128,
   parameter int TMO_W       = 16
) (
   input  logic             sd_clock,
   input  logic             reset,
   input  logic             start_rx,
   input  logic [15:0]      block_count,
   input  logic [TMO_W-1:0] timeout_value,
   input  logic [3:0]       dat_in,
   output logic             ser_enable,
   output logic             ser_reset,
   input  logic [31:0]      par_word,
   output logic             fifo_wr_en,
   output logic [31:0]      fifo_wr_data,
   input  logic             fifo_full,
   output logic             busy,
   output logic             done,
   output logic [15:0]      blocks_done,
   output logic             crc_err,
   output logic             end_err,
   output logic             timeout_err,
   output logic             overrun_err
);

   localparam int WC_W = $clog2(BLOCK_WORDS) + 1;
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BLOCK_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      DATA,
      CRC,
      END_BIT,
      FINISH
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [15:0]      blk_cnt_q;
   logic [TMO_W-1:0] tmo_val_q;
   logic [TMO_W-1:0] tmo_cnt;
   logic [2:0]       nib_cnt;
   logic [WC_W-1:0]  word_cnt;
   logic [3:0]       bit_cnt;
   logic [15:0]      crc_q [4];
   logic             mismatch;
   logic             wr_pend;

   logic       start_ok;
   logic       start_bit;
   logic       tmo_hit;
   logic       overrun;
   logic       last_nib;
   logic       end_bad;
   logic       last_blk;
   logic [3:0] crc_idx;
   logic [3:0] crc_bits;

   function automatic logic [15:0] crc_step(input logic [15:0] c,
                                            input logic b);
      logic fb;
      fb = b ^ c[15];
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   assign start_ok  = (state == IDLE) && start_rx;
   assign start_bit = (dat_in == 4'b0000);
   assign tmo_hit   = (tmo_cnt == tmo_val_q);
   assign overrun   = wr_pend && fifo_full;
   assign last_nib  = (nib_cnt == 3'd7) && (word_cnt == LAST_WORD);
   assign end_bad   = (dat_in != 4'b1111);
   assign last_blk  = ((blocks_done + 16'd1) == blk_cnt_q);
   assign crc_idx   = ~bit_cnt;

   // Expected CRC bit per lane for the current CRC-phase cycle
   always_comb begin
      crc_bits = '0;
      for (int i = 0; i < 4; i++) begin
         crc_bits[i] = crc_q[i][crc_idx];
      end
   end

   // Handshake outputs to the deserializer, FIFO and host
   always_comb begin
      ser_enable   = (state == DATA);
      ser_reset    = start_ok || ((state == WAIT_START) && start_bit);
      fifo_wr_en   = wr_pend && !fifo_full;
      fifo_wr_data = fifo_wr_en ? par_word : 32'h0;
      busy         = (state != IDLE);
      done         = (state == FINISH);
   end

   // State register
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an overrun aborts from any state
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start_rx) begin
               state_nxt = (block_count == 16'd0) ? FINISH : WAIT_START;
            end
         end
         WAIT_START: begin
            if (start_bit) begin
               state_nxt = DATA;
            end else if (tmo_hit) begin
               state_nxt = FINISH;
            end
         end
         DATA: begin
            if (last_nib) begin
               state_nxt = CRC;
            end
         end
         CRC: begin
            if (bit_cnt == 4'd15) begin
               state_nxt = END_BIT;
            end
         end
         END_BIT: begin
            if (end_bad || mismatch || last_blk) begin
               state_nxt = FINISH;
            end else begin
               state_nxt = WAIT_START;
            end
         end
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (overrun) begin
         state_nxt = FINISH;
      end
   end

   // Counters, lane CRCs, block count and sticky error flags
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         blk_cnt_q   <= '0;
         tmo_val_q   <= '0;
         tmo_cnt     <= '0;
         nib_cnt     <= '0;
         word_cnt    <= '0;
         bit_cnt     <= '0;
         mismatch    <= 1'b0;
         wr_pend     <= 1'b0;
         blocks_done <= '0;
         crc_err     <= 1'b0;
         end_err     <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            crc_q[i] <= '0;
         end
      end else begin
         wr_pend <= (state == DATA) && (nib_cnt == 3'd7);
         if (overrun) begin
            overrun_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start_rx) begin
                  blk_cnt_q   <= block_count;
                  tmo_val_q   <= timeout_value;
                  tmo_cnt     <= '0;
                  blocks_done <= '0;
                  crc_err     <= 1'b0;
                  end_err     <= 1'b0;
                  timeout_err <= 1'b0;
                  overrun_err <= 1'b0;
               end
            end
            WAIT_START: begin
               if (start_bit) begin
                  nib_cnt  <= '0;
                  word_cnt <= '0;
                  bit_cnt  <= '0;
                  mismatch <= 1'b0;
                  for (int i = 0; i < 4; i++) begin
                     crc_q[i] <= '0;
                  end
               end else if (tmo_hit) begin
                  timeout_err <= 1'b1;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DATA: begin
               for (int i = 0; i < 4; i++) begin
                  crc_q[i] <= crc_step(crc_q[i], dat_in[i]);
               end
               nib_cnt <= nib_cnt + 3'd1;
               if (nib_cnt == 3'd7) begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
            CRC: begin
               if (dat_in != crc_bits) begin
                  mismatch <= 1'b1;
               end
               bit_cnt <= bit_cnt + 4'd1;
            end
            END_BIT: begin
               if (end_bad) begin
                  end_err <= 1'b1;
               end
               if (mismatch) begin
                  crc_err <= 1'b1;
               end
               if (!end_bad && !mismatch) begin
                  blocks_done <= blocks_done + 16'd1;
                  tmo_cnt     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
